// File: rtl/mem_timer_pkg.sv
// Shared types and register-map constants for the memory-mapped machine timer.
package mem_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Word offsets inside the 8-word timer region
  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;

  // ctrl register bit positions
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Compare register resets to all ones so the interrupt stays quiet until programmed
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mem_timer_byte_merge.sv
// Byte-lane write merge: each enabled lane takes the new byte, others keep the old one.
module mem_timer_byte_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_we,
  output logic [31:0] o_merged
);

  // Per-lane select between old and new data
  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_timer.sv
// 64-bit machine timer on the word-addressed CPU bus with prescaler,
// compare interrupt and an atomic lo/hi read shadow.
//
// state   | meaning
// ST_IDLE | waiting for a selected bus request
// ST_RESP | one-cycle completion: mem_ready high, rdata valid
module mem_timer
  import mem_timer_pkg::*;
#(
  parameter logic [29:0] BASE     = 30'h3000_0000,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        irq
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_run;
  logic          r_irq_en;
  logic [31:0]   r_shadow;
  logic [31:0]   r_rdata;
  logic          r_irq;
  logic [PW-1:0] r_presc;

  logic          w_sel;
  logic          w_wr;
  logic          w_rd;
  logic [2:0]    w_off;
  logic          w_tick;
  logic [63:0]   w_mtime_inc;
  logic [31:0]   w_merge_old;
  logic [31:0]   w_merged;
  logic [31:0]   w_rd_val;
  logic [63:0]   w_mtime_next;
  logic [63:0]   w_cmp_next;
  logic          w_run_next;
  logic          w_en_next;
  logic [PW-1:0] w_presc_next;

  // Requests are only accepted in IDLE; a strobe during RESP is dropped
  assign w_sel = re && (addr[29:3] == BASE[29:3]) && (r_state == ST_IDLE);
  assign w_off = addr[2:0];
  assign w_wr  = w_sel && (we != 4'b0000);
  assign w_rd  = w_sel && (we == 4'b0000);

  assign w_tick      = r_run && (r_presc == PS_LAST);
  assign w_mtime_inc = r_mtime + 64'(w_tick);

  // Select the current register word to byte-merge with; mtime uses the incremented value
  always_comb begin
    w_merge_old = 32'h0;
    case (w_off)
      OFF_MTIME_LO:    w_merge_old = w_mtime_inc[31:0];
      OFF_MTIME_HI:    w_merge_old = w_mtime_inc[63:32];
      OFF_MTIMECMP_LO: w_merge_old = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_merge_old = r_mtimecmp[63:32];
      OFF_CTRL:        w_merge_old = {30'b0, r_irq_en, r_run};
      default:         w_merge_old = 32'h0;
    endcase
  end

  mem_timer_byte_merge u_merge (
    .i_old    (w_merge_old),
    .i_new    (wdata),
    .i_we     (we),
    .o_merged (w_merged)
  );

  // Read mux from pre-update state
  always_comb begin
    w_rd_val = 32'h0;
    case (w_off)
      OFF_MTIME_LO:    w_rd_val = r_mtime[31:0];
      OFF_MTIME_HI:    w_rd_val = r_shadow;
      OFF_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
      OFF_CTRL:        w_rd_val = {30'b0, r_irq_en, r_run};
      default:         w_rd_val = 32'h0;
    endcase
  end

  // Post-update register values: counting first, then any bus write on top
  always_comb begin
    w_mtime_next = w_mtime_inc;
    w_cmp_next   = r_mtimecmp;
    w_run_next   = r_run;
    w_en_next    = r_irq_en;
    if (w_wr) begin
      case (w_off)
        OFF_MTIME_LO:    w_mtime_next[31:0]  = w_merged;
        OFF_MTIME_HI:    w_mtime_next[63:32] = w_merged;
        OFF_MTIMECMP_LO: w_cmp_next[31:0]    = w_merged;
        OFF_MTIMECMP_HI: w_cmp_next[63:32]   = w_merged;
        OFF_CTRL: begin
          w_run_next = w_merged[CTRL_RUN];
          w_en_next  = w_merged[CTRL_IRQ_EN];
        end
        default: ;
      endcase
    end
  end

  // Prescaler: wraps on tick, holds when stopped, restarts on any ctrl write
  always_comb begin
    w_presc_next = r_presc;
    if (w_wr && (w_off == OFF_CTRL)) w_presc_next = '0;
    else if (w_tick)                 w_presc_next = '0;
    else if (r_run)                  w_presc_next = r_presc + PW'(1);
  end

  // Bus handshake next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_sel) w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, timer registers, read data and registered interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mtime    <= 64'h0;
      r_mtimecmp <= MTIMECMP_RST;
      r_run      <= 1'b0;
      r_irq_en   <= 1'b0;
      r_shadow   <= 32'h0;
      r_rdata    <= 32'h0;
      r_irq      <= 1'b0;
      r_presc    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_cmp_next;
      r_run      <= w_run_next;
      r_irq_en   <= w_en_next;
      r_presc    <= w_presc_next;
      r_rdata    <= w_sel ? w_rd_val : 32'h0;
      if (w_rd && (w_off == OFF_MTIME_LO)) r_shadow <= r_mtime[63:32];
      r_irq      <= w_en_next && (w_mtime_next >= w_cmp_next);
    end
  end

  assign rdata     = r_rdata;
  assign mem_ready = (r_state == ST_RESP);
  assign irq       = r_irq;

endmodule

// File: tb/tb_mem_timer.sv
// Bench for mem_timer: behavioural register model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_mem_timer;

  localparam logic [29:0] BASE     = 30'h3000_0000;
  localparam int          PRESCALE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        irq;

  mem_timer #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .re        (re),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .mem_ready (mem_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the timer's architectural state
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow;
  logic        m_run, m_en, m_resp;
  int          m_pcnt;
  logic        m_valid = 1'b0;
  logic        e_ready, e_irq, e_isread;
  logic [31:0] e_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic        sel, wr, tick;
    logic [2:0]  off;
    logic [31:0] rv, c;
    m_valid = 1'b1;
    if (reset) begin
      m_mtime = 64'h0; m_cmp = '1; m_shadow = 32'h0;
      m_run = 1'b0; m_en = 1'b0; m_resp = 1'b0; m_pcnt = 0;
      e_ready = 1'b0; e_rdata = 32'h0; e_irq = 1'b0; e_isread = 1'b0;
      return;
    end
    sel = re && !m_resp && (addr[29:3] == BASE[29:3]);
    off = addr[2:0];
    wr  = sel && (we != 4'b0);
    case (off)
      3'd0:    rv = m_mtime[31:0];
      3'd1:    rv = m_shadow;
      3'd2:    rv = m_cmp[31:0];
      3'd3:    rv = m_cmp[63:32];
      3'd4:    rv = {30'b0, m_en, m_run};
      default: rv = 32'h0;
    endcase
    tick = m_run && (m_pcnt == PRESCALE - 1);
    if (m_run) m_pcnt = tick ? 0 : m_pcnt + 1;
    if (sel && we == 4'b0 && off == 3'd0) m_shadow = m_mtime[63:32];
    m_mtime = m_mtime + (tick ? 64'd1 : 64'd0);
    if (wr) begin
      case (off)
        3'd0: m_mtime[31:0]  = merge(m_mtime[31:0], wdata, we);
        3'd1: m_mtime[63:32] = merge(m_mtime[63:32], wdata, we);
        3'd2: m_cmp[31:0]    = merge(m_cmp[31:0], wdata, we);
        3'd3: m_cmp[63:32]   = merge(m_cmp[63:32], wdata, we);
        3'd4: begin
          c = merge({30'b0, m_en, m_run}, wdata, we);
          m_run = c[0]; m_en = c[1]; m_pcnt = 0;
        end
        default: ;
      endcase
    end
    e_ready  = sel;
    e_rdata  = sel ? rv : 32'h0;
    e_isread = sel && (we == 4'b0);
    m_resp   = sel;
    e_irq    = m_en && (m_mtime >= m_cmp);
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_ready", {63'b0, mem_ready}, {63'b0, e_ready});
      chk("irq", {63'b0, irq}, {63'b0, e_irq});
      if (!e_ready) chk("rdata_idle", {32'b0, rdata}, 64'h0);
      else if (e_isread) chk("rdata", {32'b0, rdata}, {32'b0, e_rdata});
    end
  end

  // Apply one cycle of inputs, step the model at the edge, return at the next falling edge
  task automatic drive(input logic r, input logic [3:0] w, input logic [29:0] a,
                       input logic [31:0] d, input logic rs);
    re = r; we = w; addr = a; wdata = d; reset = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 4'b0, 30'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0, 30'h0, 32'h0, 1'b1);
    drive(1'b0, 4'b0, 30'h0, 32'h0, 1'b1);
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [3:0] w, input logic [31:0] d);
    drive(1'b1, w, BASE + 30'(off), d, 1'b0);
    idle();
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
    drive(1'b1, 4'b0, BASE + 30'(off), 32'h0, 1'b0);
    d = rdata;
    idle();
  endtask

  initial begin
    logic [31:0] d;
    int n;
    re = 1'b0; we = 4'b0; addr = 30'h0; wdata = 32'h0; reset = 1'b1;

    // 1: reset state, read ctrl, mtime frozen while stopped
    do_reset();
    chk("rst_irq", {63'b0, irq}, 64'h0);
    chk("rst_ready", {63'b0, mem_ready}, 64'h0);
    drive(1'b1, 4'b0, BASE + 30'd4, 32'h0, 1'b0);
    chk("ctrl_ready", {63'b0, mem_ready}, 64'h1);
    chk("ctrl_rd", {32'b0, rdata}, 64'h0);
    idle();
    chk("ready_one_cycle", {63'b0, mem_ready}, 64'h0);
    repeat (10) idle();
    bus_read(3'd0, d);
    chk("mtime_frozen", {32'b0, d}, 64'h0);

    // 2: run with prescale 4 for 40 cycles
    do_reset();
    drive(1'b1, 4'hF, BASE + 30'd4, 32'h1, 1'b0);
    repeat (40) idle();
    bus_read(3'd0, d);
    chk("count_40", {32'b0, d}, 64'd10);

    // 3: lo rollover and atomic hi shadow
    do_reset();
    bus_write(3'd0, 4'hF, 32'hFFFF_FFFF);
    bus_write(3'd4, 4'hF, 32'h1);
    repeat (5) idle();
    bus_write(3'd4, 4'hF, 32'h0);
    bus_read(3'd0, d);
    chk("roll_lo", {32'b0, d}, 64'h0);
    bus_write(3'd1, 4'hF, 32'h5);
    bus_read(3'd1, d);
    chk("shadow_hi", {32'b0, d}, 64'h1);
    bus_read(3'd1, d);
    chk("shadow_hold", {32'b0, d}, 64'h1);

    // 4: compare interrupt timing and release
    do_reset();
    bus_write(3'd3, 4'hF, 32'h0);
    bus_write(3'd2, 4'hF, 32'd100);
    drive(1'b1, 4'hF, BASE + 30'd4, 32'h3, 1'b0);
    n = 0;
    do begin
      idle();
      n++;
    end while (!irq && n < 600);
    chk("irq_cycle", 64'(n), 64'd400);
    chk("irq_high", {63'b0, irq}, 64'h1);
    drive(1'b1, 4'hF, BASE + 30'd3, 32'h1, 1'b0);
    chk("irq_release", {63'b0, irq}, 64'h0);
    idle();

    // 5: byte-lane write, reserved register, out-of-region request
    do_reset();
    bus_write(3'd2, 4'hF, 32'h1122_3344);
    bus_write(3'd2, 4'b0010, 32'h0000_AB00);
    bus_read(3'd2, d);
    chk("byte_merge", {32'b0, d}, 64'h1122_AB44);
    bus_read(3'd3, d);
    chk("cmp_hi_keep", {32'b0, d}, 64'hFFFF_FFFF);
    bus_write(3'd6, 4'hF, 32'hDEAD_BEEF);
    bus_read(3'd6, d);
    chk("reserved_rd", {32'b0, d}, 64'h0);
    drive(1'b1, 4'b0, BASE + 30'd8, 32'h0, 1'b0);
    chk("out_of_region", {63'b0, mem_ready}, 64'h0);
    idle();

    // 6: reset during a transaction
    drive(1'b1, 4'hF, BASE + 30'd2, 32'h55, 1'b1);
    chk("rst_with_re", {63'b0, mem_ready}, 64'h0);
    idle();
    bus_read(3'd2, d);
    chk("rst_discard", {32'b0, d}, 64'hFFFF_FFFF);
    drive(1'b1, 4'hF, BASE + 30'd2, 32'h77, 1'b0);
    drive(1'b0, 4'b0, 30'h0, 32'h0, 1'b1);
    chk("rst_in_resp", {63'b0, mem_ready}, 64'h0);
    idle();
    bus_read(3'd2, d);
    chk("rst_resp_reg", {32'b0, d}, 64'hFFFF_FFFF);

    // Randomized bus traffic checked by the model
    for (int k = 0; k < 800; k++) begin
      int          r;
      logic [2:0]  off;
      logic [29:0] a;
      logic [3:0]  w;
      logic [31:0] dd;
      r   = int'($urandom_range(0, 99));
      off = 3'($urandom_range(0, 7));
      if (r < 2) begin
        drive(1'b0, 4'b0, 30'h0, 32'h0, 1'b1);
      end else if (r < 35) begin
        idle();
      end else begin
        a  = ($urandom_range(0, 9) == 0) ? 30'($urandom) : BASE + 30'(off);
        w  = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
        case (off)
          3'd1, 3'd3: dd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1));
          3'd2:       dd = 32'($urandom_range(0, 300));
          3'd4:       dd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3;
          default:    dd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
        endcase
        drive(1'b1, w, a, dd, 1'b0);
        if ($urandom_range(0, 4) == 0) drive(1'b1, 4'b0, BASE, 32'h0, 1'b0);
        else idle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
